// File: rtl/spu_dual_issue_scoreboard_pkg.sv
// Shared definitions for the SPU dual-issue check.
//   - instruction format codes, pipe encoding
//   - default register-address / latency widths
//   - slot_t: one decoded slot at default widths (handy for producers/benches)
package spu_dual_issue_scoreboard_pkg;

  localparam int REG_AW_DEF   = 7;
  localparam int LAT_W_DEF    = 3;
  localparam int NUM_REGS_DEF = 1 << REG_AW_DEF;

  typedef enum logic [2:0] {
    FMT_RRR  = 3'd0,
    FMT_RR   = 3'd1,
    FMT_RI7  = 3'd2,
    FMT_RI10 = 3'd3,
    FMT_RI16 = 3'd4,
    FMT_RI18 = 3'd5
  } fmt_e;

  typedef enum logic {
    PIPE_EVEN = 1'b0,
    PIPE_ODD  = 1'b1
  } pipe_e;

  typedef struct packed {
    logic                  valid;
    logic                  pipe;
    logic [REG_AW_DEF-1:0] ra;
    logic [REG_AW_DEF-1:0] rb;
    logic [REG_AW_DEF-1:0] rc;
    logic [2:0]            use_; // {ra,rb,rc}
    logic [REG_AW_DEF-1:0] rt;
    logic                  wr;
    logic [LAT_W_DEF-1:0]  lat;
  } slot_t;

endpackage

// File: rtl/spu_dual_issue_scoreboard_if.sv
// Decoder-pair / issue-decision bundle.
//   master: decoder side, drives the two slots and flush, sees the decision.
//   slave : scoreboard side.
// Outputs: issue0/issue1/issue_cnt/stall (combinational), busy_regs (registered).
interface spu_dual_issue_scoreboard_if #(
  parameter int REG_AW = 7,
  parameter int LAT_W  = 3
);
  logic              flush;
  logic              s0_valid, s0_pipe, s0_wr;
  logic [REG_AW-1:0] s0_ra, s0_rb, s0_rc, s0_rt;
  logic [2:0]        s0_use;
  logic [LAT_W-1:0]  s0_lat;
  logic              s1_valid, s1_pipe, s1_wr;
  logic [REG_AW-1:0] s1_ra, s1_rb, s1_rc, s1_rt;
  logic [2:0]        s1_use;
  logic [LAT_W-1:0]  s1_lat;
  logic              issue0, issue1, stall;
  logic [1:0]        issue_cnt;
  logic [REG_AW:0]   busy_regs;

  modport master (
    output flush,
    output s0_valid, s0_pipe, s0_ra, s0_rb, s0_rc, s0_use, s0_rt, s0_wr, s0_lat,
    output s1_valid, s1_pipe, s1_ra, s1_rb, s1_rc, s1_use, s1_rt, s1_wr, s1_lat,
    input  issue0, issue1, issue_cnt, stall, busy_regs
  );

  modport slave (
    input  flush,
    input  s0_valid, s0_pipe, s0_ra, s0_rb, s0_rc, s0_use, s0_rt, s0_wr, s0_lat,
    input  s1_valid, s1_pipe, s1_ra, s1_rb, s1_rc, s1_use, s1_rt, s1_wr, s1_lat,
    output issue0, issue1, issue_cnt, stall, busy_regs
  );
endinterface

// File: rtl/spu_dual_issue_scoreboard_regsb.sv
// spu_reg_scoreboard: per-register result-latency counters.
//   clk, rst        : clock, async active-high reset (clears all counters)
//   i_ld*_en/rt/lat : two load ports (issuing writers); load beats decrement
//   i_q*_addr/o_q*_rdy : two 3-source ready-query ports, index 2=ra,1=rb,0=rc
//   i_c*_addr/o_c*_cnt : two raw counter read ports (for WAW compare)
//   o_busy          : registered count of nonzero counters after the update
module spu_reg_scoreboard #(
  parameter int NUM_REGS = 128,
  parameter int REG_AW   = 7,
  parameter int LAT_W    = 3,
  parameter bit FWD_EN   = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_ld0_en,
  input  logic [REG_AW-1:0]      i_ld0_rt,
  input  logic [LAT_W-1:0]       i_ld0_lat,
  input  logic                   i_ld1_en,
  input  logic [REG_AW-1:0]      i_ld1_rt,
  input  logic [LAT_W-1:0]       i_ld1_lat,
  input  logic [2:0][REG_AW-1:0] i_q0_addr,
  input  logic [2:0][REG_AW-1:0] i_q1_addr,
  output logic [2:0]             o_q0_rdy,
  output logic [2:0]             o_q1_rdy,
  input  logic [REG_AW-1:0]      i_c0_addr,
  input  logic [REG_AW-1:0]      i_c1_addr,
  output logic [LAT_W-1:0]       o_c0_cnt,
  output logic [LAT_W-1:0]       o_c1_cnt,
  output logic [REG_AW:0]        o_busy
);

  logic [NUM_REGS-1:0][LAT_W-1:0] r_cnt, w_cnt_nxt;
  logic [REG_AW:0]                r_busy, w_pop;

  // With forwarding, a result one cycle out is bypassed to the reader.
  function automatic logic f_rdy(input logic [LAT_W-1:0] c);
    return (c == '0) || (FWD_EN && (c == LAT_W'(1)));
  endfunction

  always_comb begin
    w_cnt_nxt = r_cnt;
    w_pop     = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (r_cnt[i] != '0) w_cnt_nxt[i] = r_cnt[i] - LAT_W'(1);
      // The two ports never hit the same register (top blocks that pairing).
      if (i_ld1_en && (i_ld1_rt == REG_AW'(i))) w_cnt_nxt[i] = i_ld1_lat;
      if (i_ld0_en && (i_ld0_rt == REG_AW'(i))) w_cnt_nxt[i] = i_ld0_lat;
      w_pop = w_pop + {{REG_AW{1'b0}}, |w_cnt_nxt[i]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt  <= '0;
      r_busy <= '0;
    end else begin
      r_cnt  <= w_cnt_nxt;
      r_busy <= w_pop;
    end
  end

  for (genvar k = 0; k < 3; k++) begin : g_q
    assign o_q0_rdy[k] = f_rdy(r_cnt[i_q0_addr[k]]);
    assign o_q1_rdy[k] = f_rdy(r_cnt[i_q1_addr[k]]);
  end

  assign o_c0_cnt = r_cnt[i_c0_addr];
  assign o_c1_cnt = r_cnt[i_c1_addr];
  assign o_busy   = r_busy;

endmodule

// File: rtl/spu_dual_issue_scoreboard.sv
// spu_dual_issue_scoreboard: in-order dual-issue decision for a decoded pair.
//   clk, rst : clock, async active-high reset
//   bus      : slave side of spu_dual_issue_scoreboard_if (slots, flush in;
//              issue0/issue1/issue_cnt/stall combinational, busy_regs registered)
// Decision is combinational from registered counters + slot fields, so an
// instruction issues in the same cycle it is presented.
module spu_dual_issue_scoreboard
  import spu_dual_issue_scoreboard_pkg::*;
#(
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int REG_AW   = REG_AW_DEF,
  parameter int LAT_W    = LAT_W_DEF,
  parameter bit FWD_EN   = 1'b1
) (
  input logic                     clk,
  input logic                     rst,
  spu_dual_issue_scoreboard_if.slave bus
);

  logic [2:0][REG_AW-1:0] w_q0, w_q1;
  logic [2:0]             w_rdy0, w_rdy1;
  logic [LAT_W-1:0]       w_cnt_rt0, w_cnt_rt1;
  logic                   w_src0_ok, w_src1_ok, w_waw0, w_waw1;
  logic                   w_raw01, w_waw01, w_issue0, w_issue1;

  assign w_q0 = {bus.s0_ra, bus.s0_rb, bus.s0_rc};
  assign w_q1 = {bus.s1_ra, bus.s1_rb, bus.s1_rc};

  spu_reg_scoreboard #(
    .NUM_REGS(NUM_REGS), .REG_AW(REG_AW), .LAT_W(LAT_W), .FWD_EN(FWD_EN)
  ) u_sb (
    .clk       (clk),
    .rst       (rst),
    .i_ld0_en  (w_issue0 & bus.s0_wr),
    .i_ld0_rt  (bus.s0_rt),
    .i_ld0_lat (bus.s0_lat),
    .i_ld1_en  (w_issue1 & bus.s1_wr),
    .i_ld1_rt  (bus.s1_rt),
    .i_ld1_lat (bus.s1_lat),
    .i_q0_addr (w_q0),
    .i_q1_addr (w_q1),
    .o_q0_rdy  (w_rdy0),
    .o_q1_rdy  (w_rdy1),
    .i_c0_addr (bus.s0_rt),
    .i_c1_addr (bus.s1_rt),
    .o_c0_cnt  (w_cnt_rt0),
    .o_c1_cnt  (w_cnt_rt1),
    .o_busy    (bus.busy_regs)
  );

  // Unused sources never block.
  assign w_src0_ok = &(~bus.s0_use | w_rdy0);
  assign w_src1_ok = &(~bus.s1_use | w_rdy1);

  // A pending older write finishing after ours would clobber the newer value.
  assign w_waw0 = bus.s0_wr & (w_cnt_rt0 > bus.s0_lat);
  assign w_waw1 = bus.s1_wr & (w_cnt_rt1 > bus.s1_lat);

  // Intra-pair dependencies: slot1 cannot consume or overwrite slot0's result.
  assign w_raw01 = bus.s0_wr & |(bus.s1_use & {bus.s1_ra == bus.s0_rt,
                                               bus.s1_rb == bus.s0_rt,
                                               bus.s1_rc == bus.s0_rt});
  assign w_waw01 = bus.s0_wr & bus.s1_wr & (bus.s1_rt == bus.s0_rt);

  assign w_issue0 = bus.s0_valid & ~bus.flush & w_src0_ok & ~w_waw0;
  assign w_issue1 = w_issue0 & bus.s1_valid & w_src1_ok & ~w_waw1 &
                    (bus.s1_pipe != bus.s0_pipe) & ~w_raw01 & ~w_waw01;

  assign bus.issue0    = w_issue0;
  assign bus.issue1    = w_issue1;
  assign bus.issue_cnt = {1'b0, w_issue0} + {1'b0, w_issue1};
  assign bus.stall     = bus.s0_valid & ~w_issue0;

endmodule
